// File: rtl/sha256_stream_update.sv
// SHA-256 compression engine that streams 16-word blocks in over a valid/ready
// port and chains the hash across num_blocks blocks, RPC rounds per clock.
//
// state  | meaning
// IDLE   | waiting for start; hash outputs hold the last result
// LOAD   | accepting the 16 message words of the current block
// ROUND  | RPC compression rounds per clock for 64/RPC clocks
// UPDATE | fold working variables into H, then next block or finish
module sha256_stream_update #(
  parameter int RPC   = 1,
  parameter int BLK_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             use_midstate,
  input  logic [255:0]     midstate,
  input  logic [BLK_W-1:0] num_blocks,
  input  logic             w_valid,
  input  logic [31:0]      w_data,
  output logic             w_ready,
  output logic [31:0]      hash0,
  output logic [31:0]      hash1,
  output logic [31:0]      hash2,
  output logic [31:0]      hash3,
  output logic [31:0]      hash4,
  output logic [31:0]      hash5,
  output logic [31:0]      hash6,
  output logic [31:0]      hash7,
  output logic [BLK_W-1:0] cur_block,
  output logic             busy,
  output logic             done
);

  if (!(RPC == 1 || RPC == 2 || RPC == 4)) begin : g_bad_rpc
    $fatal(1, "sha256_stream_update: RPC must be 1, 2 or 4");
  end

  localparam logic [5:0]       ROUND_LAST = 6'(64 / RPC - 1);
  localparam logic [5:0]       BASE_LAST  = 6'(64 - RPC);
  localparam logic [BLK_W-1:0] BLK_ONE    = 1;

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  typedef enum logic [1:0] {IDLE, LOAD, ROUND, UPDATE} state_t;

  state_t           state, state_nxt;
  logic [31:0]      h_q   [8];
  logic [31:0]      wv_q  [8];
  logic [31:0]      w_win [16];
  logic [3:0]       word_left;
  logic [5:0]       rnd_cnt;
  logic [BLK_W-1:0] nblk_q;
  logic             done_q;

  logic             last_word;
  logic             rnd_last;
  logic [BLK_W-1:0] cur_next;
  logic             more_blocks;

  assign last_word   = (word_left == 4'd0);
  assign rnd_last    = (rnd_cnt == 6'd0);
  assign cur_next    = cur_block + BLK_ONE;
  assign more_blocks = (cur_next < nblk_q);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    w_ready   = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start && num_blocks != '0) state_nxt = LOAD;
      end
      LOAD: begin
        w_ready = 1'b1;
        if (w_valid && last_word) state_nxt = ROUND;
      end
      ROUND:   if (rnd_last) state_nxt = UPDATE;
      UPDATE:  state_nxt = more_blocks ? LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The window always holds W[t..t+15]; each round consumes w[0] and appends W[t+16].
  logic [31:0] rv [8];
  logic [31:0] rw [16];
  logic [31:0] t1, t2, w_new;
  logic [5:0]  k_base;

  always_comb begin
    rv     = wv_q;
    rw     = w_win;
    t1     = '0;
    t2     = '0;
    w_new  = '0;
    k_base = BASE_LAST - 6'(int'(rnd_cnt) * RPC);
    for (int r = 0; r < RPC; r++) begin
      t1 = rv[7] + bsig1(rv[4]) + ((rv[4] & rv[5]) ^ (~rv[4] & rv[6]))
         + K[k_base + 6'(r)] + rw[0];
      t2 = bsig0(rv[0]) + ((rv[0] & rv[1]) ^ (rv[0] & rv[2]) ^ (rv[1] & rv[2]));
      for (int i = 7; i > 0; i--) rv[i] = rv[i-1];
      rv[4] = rv[4] + t1;
      rv[0] = t1 + t2;
      w_new = ssig1(rw[14]) + rw[9] + ssig0(rw[1]) + rw[0];
      for (int i = 0; i < 15; i++) rw[i] = rw[i+1];
      rw[15] = w_new;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) h_q[i] <= IV[i];
      cur_block <= '0;
      nblk_q    <= '0;
      word_left <= '0;
      rnd_cnt   <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (start) begin
          for (int i = 0; i < 8; i++)
            h_q[i] <= use_midstate ? midstate[255-32*i -: 32] : IV[i];
          cur_block <= '0;
          nblk_q    <= num_blocks;
          word_left <= 4'd15;
          done_q    <= (num_blocks == '0);
        end
        LOAD: if (w_valid) begin
          for (int i = 0; i < 15; i++) w_win[i] <= w_win[i+1];
          w_win[15] <= w_data;
          if (last_word) begin
            wv_q    <= h_q;
            rnd_cnt <= ROUND_LAST;
          end else begin
            word_left <= word_left - 4'd1;
          end
        end
        ROUND: begin
          wv_q  <= rv;
          w_win <= rw;
          if (!rnd_last) rnd_cnt <= rnd_cnt - 6'd1;
        end
        UPDATE: begin
          for (int i = 0; i < 8; i++) h_q[i] <= h_q[i] + wv_q[i];
          if (more_blocks) begin
            cur_block <= cur_next;
            word_left <= 4'd15;
          end else begin
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign hash0 = h_q[0];
  assign hash1 = h_q[1];
  assign hash2 = h_q[2];
  assign hash3 = h_q[3];
  assign hash4 = h_q[4];
  assign hash5 = h_q[5];
  assign hash6 = h_q[6];
  assign hash7 = h_q[7];
  assign done  = done_q;

endmodule

// File: tb/tb_sha256_stream_update.sv
// Bench for sha256_stream_update: three instances (RPC 1/2/4) checked against a
// plain full-schedule SHA-256 model and the published test vectors.
module tb_sha256_stream_update;

  localparam int BLK_W     = 16;
  localparam int RUN_LIMIT = 2000;

  localparam logic [255:0] IV_TB  = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_H  = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] TWO_H  = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  localparam logic [31:0] K_TB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] TWO_MSG [14] = '{
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869, 32'h6768696a,
    32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071
  };

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start_s    [3];
  logic             use_mid_s  [3];
  logic [255:0]     mid_s      [3];
  logic [BLK_W-1:0] nblk_s     [3];
  logic             w_valid_s  [3];
  logic [31:0]      w_data_s   [3];
  logic             w_ready_o  [3];
  logic [31:0]      hash_o     [3][8];
  logic [BLK_W-1:0] cur_o      [3];
  logic             busy_o     [3];
  logic             done_o     [3];

  int checks = 0;
  int errors = 0;
  logic [31:0] msg_q [$];

  typedef struct {
    logic [255:0]     hash;
    int               edges;
    int               stalls;
    bit               saw_ready;
    logic [BLK_W-1:0] cur;
    logic             done_next;
    logic             busy_next;
    logic [255:0]     hash_next;
  } run_t;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    sha256_stream_update #(.RPC(1 << gi), .BLK_W(BLK_W)) u_dut (
      .clk(clk), .reset(reset), .start(start_s[gi]), .use_midstate(use_mid_s[gi]),
      .midstate(mid_s[gi]), .num_blocks(nblk_s[gi]), .w_valid(w_valid_s[gi]), .w_data(w_data_s[gi]),
      .w_ready(w_ready_o[gi]),
      .hash0(hash_o[gi][0]), .hash1(hash_o[gi][1]), .hash2(hash_o[gi][2]), .hash3(hash_o[gi][3]),
      .hash4(hash_o[gi][4]), .hash5(hash_o[gi][5]), .hash6(hash_o[gi][6]), .hash7(hash_o[gi][7]),
      .cur_block(cur_o[gi]), .busy(busy_o[gi]), .done(done_o[gi])
    );
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [31:0] blk [16]);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
    logic [255:0] v, hout;
    for (int i = 0; i < 16; i++) w[i] = blk[i];
    for (int i = 16; i < 64; i++)
      w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
           + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    {a, b, c, d, e, f, g, hh} = hin;
    for (int t = 0; t < 64; t++) begin
      t1 = hh + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + K_TB[t] + w[t];
      t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    v = {a, b, c, d, e, f, g, hh};
    for (int i = 0; i < 8; i++) hout[255-32*i -: 32] = hin[255-32*i -: 32] + v[255-32*i -: 32];
    return hout;
  endfunction

  function automatic logic [255:0] ref_hash(input bit use_mid, input logic [255:0] mid, input int nblk);
    logic [255:0] hv;
    logic [31:0]  blk [16];
    hv = use_mid ? mid : IV_TB;
    for (int bi = 0; bi < nblk; bi++) begin
      for (int j = 0; j < 16; j++) blk[j] = msg_q[bi*16 + j];
      hv = compress(hv, blk);
    end
    return hv;
  endfunction

  // ---------------- stimulus helpers ----------------
  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [255:0] get_hash(input int k);
    return {hash_o[k][0], hash_o[k][1], hash_o[k][2], hash_o[k][3],
            hash_o[k][4], hash_o[k][5], hash_o[k][6], hash_o[k][7]};
  endfunction

  function automatic int blk_edges(input int k);
    return 17 + (64 >> k);
  endfunction

  task automatic load_abc();
    msg_q.delete();
    msg_q.push_back(32'h61626380);
    repeat (14) msg_q.push_back(32'h0);
    msg_q.push_back(32'h00000018);
  endtask

  // which: 0 = both blocks, 1 = first block only, 2 = second block only
  task automatic load_two(input int which);
    msg_q.delete();
    if (which != 2) begin
      for (int i = 0; i < 14; i++) msg_q.push_back(TWO_MSG[i]);
      msg_q.push_back(32'h80000000);
      msg_q.push_back(32'h0);
    end
    if (which != 1) begin
      repeat (15) msg_q.push_back(32'h0);
      msg_q.push_back(32'h000001c0);
    end
  endtask

  task automatic load_random(input int nblk);
    msg_q.delete();
    repeat (nblk * 16) msg_q.push_back($urandom);
  endtask

  // Runs one hash on instance k; edges counts clock edges after the start edge
  // until done is first seen. glitch_at pulses start (with junk inputs) mid-run.
  task automatic run_hash(input int k, input bit use_mid, input logic [255:0] mid, input int nblk,
                          input bit stall, input int glitch_at, output run_t res);
    int widx;
    bit v;
    widx = 0;
    res.edges = 0;
    res.stalls = 0;
    res.saw_ready = 0;
    @(posedge clk); #1;
    start_s[k] = 1'b1; use_mid_s[k] = use_mid; mid_s[k] = mid;
    nblk_s[k] = BLK_W'(nblk); w_valid_s[k] = 1'b0;
    @(posedge clk); #1;
    start_s[k] = 1'b0;
    if (w_ready_o[k] === 1'b1 && nblk == 0) res.saw_ready = 1;
    while (done_o[k] !== 1'b1 && res.edges < RUN_LIMIT) begin
      if (w_ready_o[k] === 1'b1) begin
        res.saw_ready = 1;
        v = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        if (!v) res.stalls++;
        w_valid_s[k] = v;
        w_data_s[k]  = (v && widx < msg_q.size()) ? msg_q[widx] : $urandom;
      end else begin
        v = 1'b0;
        w_valid_s[k] = 1'($urandom_range(0, 1));
        w_data_s[k]  = $urandom;
      end
      if (res.edges == glitch_at) begin
        start_s[k] = 1'b1; use_mid_s[k] = 1'b1; mid_s[k] = rand256(); nblk_s[k] = BLK_W'(5);
      end else begin
        start_s[k] = 1'b0;
      end
      @(posedge clk); #1;
      res.edges++;
      if (v) widx++;
    end
    checks++;
    if (res.edges >= RUN_LIMIT) begin
      errors++;
      $display("FAIL run_timeout dut%0d: done not seen within %0d edges", k, res.edges);
    end
    res.hash = get_hash(k);
    res.cur  = cur_o[k];
    w_valid_s[k] = 1'b0;
    start_s[k]   = 1'b0;
    @(posedge clk); #1;
    res.done_next = done_o[k];
    res.busy_next = busy_o[k];
    res.hash_next = get_hash(k);
    if (w_ready_o[k] === 1'b1) res.saw_ready = 1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (busy_o[k] !== 1'b0 || done_o[k] !== 1'b0 || w_ready_o[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_ctrl dut%0d: busy=%b done=%b w_ready=%b, required 0 0 0",
                 k, busy_o[k], done_o[k], w_ready_o[k]);
      end
      checks++;
      if (cur_o[k] !== '0) begin
        errors++;
        $display("FAIL reset_cur dut%0d: got %0d, required 0", k, cur_o[k]);
      end
      checks++;
      if (get_hash(k) !== IV_TB) begin
        errors++;
        $display("FAIL reset_hash dut%0d: got %h, required %h", k, get_hash(k), IV_TB);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_abc();
    run_t r;
    load_abc();
    run_hash(0, 1'b0, '0, 1, 1'b0, -1, r);
    checks++;
    if (r.hash !== ABC_H) begin
      errors++; $display("FAIL abc_hash: got %h, required %h", r.hash, ABC_H);
    end
    checks++;
    if (r.edges != 81) begin
      errors++; $display("FAIL abc_latency: got %0d edges, required 81", r.edges);
    end
    checks++;
    if (r.done_next !== 1'b0 || r.busy_next !== 1'b0) begin
      errors++; $display("FAIL abc_done_pulse: done=%b busy=%b next cycle, required 0 0", r.done_next, r.busy_next);
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (get_hash(0) !== ABC_H) begin
      errors++; $display("FAIL abc_hold: got %h, required %h", get_hash(0), ABC_H);
    end
  endtask

  task automatic test_two_block();
    run_t r;
    load_two(0);
    for (int k = 0; k < 3; k++) begin
      run_hash(k, 1'b0, '0, 2, 1'b0, -1, r);
      checks++;
      if (r.hash !== TWO_H) begin
        errors++; $display("FAIL two_hash rpc%0d: got %h, required %h", 1 << k, r.hash, TWO_H);
      end
      checks++;
      if (r.edges != 2 * blk_edges(k)) begin
        errors++; $display("FAIL two_latency rpc%0d: got %0d, required %0d", 1 << k, r.edges, 2 * blk_edges(k));
      end
      checks++;
      if (r.cur !== BLK_W'(1)) begin
        errors++; $display("FAIL two_cur_block rpc%0d: got %0d, required 1", 1 << k, r.cur);
      end
    end
  endtask

  task automatic test_midstate_chain();
    run_t r1, r2;
    logic [255:0] exp1;
    load_two(1);
    exp1 = ref_hash(1'b0, '0, 1);
    run_hash(0, 1'b0, '0, 1, 1'b0, -1, r1);
    checks++;
    if (r1.hash !== exp1) begin
      errors++; $display("FAIL chain_first: got %h, required %h", r1.hash, exp1);
    end
    load_two(2);
    run_hash(0, 1'b1, exp1, 1, 1'b0, -1, r2);
    checks++;
    if (r2.hash !== TWO_H) begin
      errors++; $display("FAIL chain_final: got %h, required %h", r2.hash, TWO_H);
    end
  endtask

  task automatic test_backpressure();
    run_t ra, rb;
    logic [255:0] exp;
    load_random(2);
    exp = ref_hash(1'b0, '0, 2);
    run_hash(1, 1'b0, '0, 2, 1'b0, -1, ra);
    run_hash(1, 1'b0, '0, 2, 1'b1, -1, rb);
    checks++;
    if (ra.hash !== exp) begin
      errors++; $display("FAIL bp_nostall_hash: got %h, required %h", ra.hash, exp);
    end
    checks++;
    if (rb.hash !== exp) begin
      errors++; $display("FAIL bp_stall_hash: got %h, required %h", rb.hash, exp);
    end
    checks++;
    if (rb.edges != ra.edges + rb.stalls || ra.edges != 2 * blk_edges(1)) begin
      errors++;
      $display("FAIL bp_latency: stalled %0d unstalled %0d stalls %0d, required %0d and %0d",
               rb.edges, ra.edges, rb.stalls, 2 * blk_edges(1) + rb.stalls, 2 * blk_edges(1));
    end
  endtask

  task automatic test_zero_blocks();
    run_t r;
    logic [255:0] mid;
    mid = rand256();
    run_hash(0, 1'b1, mid, 0, 1'b0, -1, r);
    checks++;
    if (r.edges != 0) begin
      errors++; $display("FAIL zero_latency: done after %0d edges, required 0", r.edges);
    end
    checks++;
    if (r.hash !== mid) begin
      errors++; $display("FAIL zero_hash: got %h, required %h", r.hash, mid);
    end
    checks++;
    if (r.saw_ready || r.done_next !== 1'b0 || r.busy_next !== 1'b0) begin
      errors++;
      $display("FAIL zero_ctrl: saw_ready=%0d done_next=%b busy_next=%b, required 0 0 0",
               r.saw_ready, r.done_next, r.busy_next);
    end
  endtask

  task automatic test_reset_abort();
    run_t r;
    load_abc();
    @(posedge clk); #1;
    start_s[0] = 1'b1; use_mid_s[0] = 1'b0; nblk_s[0] = BLK_W'(1);
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    for (int j = 0; j < 16; j++) begin
      w_valid_s[0] = 1'b1; w_data_s[0] = msg_q[j];
      @(posedge clk); #1;
    end
    w_valid_s[0] = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (busy_o[0] !== 1'b1 || w_ready_o[0] !== 1'b0) begin
      errors++; $display("FAIL abort_in_round: busy=%b w_ready=%b, required 1 0", busy_o[0], w_ready_o[0]);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (get_hash(0) !== IV_TB) begin
      errors++; $display("FAIL abort_hash: got %h, required %h", get_hash(0), IV_TB);
    end
    checks++;
    if (busy_o[0] !== 1'b0 || done_o[0] !== 1'b0 || cur_o[0] !== '0) begin
      errors++; $display("FAIL abort_ctrl: busy=%b done=%b cur=%0d, required 0 0 0", busy_o[0], done_o[0], cur_o[0]);
    end
    reset = 1'b0;
    for (int gl = 0; gl < 2; gl++) begin
      run_hash(0, 1'b0, '0, 1, 1'b0, (gl == 0) ? 5 : 40, r);
      checks++;
      if (r.hash !== ABC_H || r.edges != 81) begin
        errors++;
        $display("FAIL busy_start_ignored glitch%0d: hash %h after %0d edges, required %h after 81",
                 gl, r.hash, r.edges, ABC_H);
      end
    end
  endtask

  task automatic test_random();
    run_t r;
    logic [255:0] mid, exp;
    int k, nblk;
    bit um, st;
    for (int it = 0; it < 6; it++) begin
      k    = $urandom_range(0, 2);
      nblk = $urandom_range(1, 3);
      um   = 1'($urandom_range(0, 1));
      st   = 1'($urandom_range(0, 1));
      mid  = rand256();
      load_random(nblk);
      exp  = ref_hash(um, mid, nblk);
      run_hash(k, um, mid, nblk, st, -1, r);
      checks++;
      if (r.hash !== exp) begin
        errors++; $display("FAIL rand_hash it%0d rpc%0d: got %h, required %h", it, 1 << k, r.hash, exp);
      end
      checks++;
      if (r.edges != nblk * blk_edges(k) + r.stalls) begin
        errors++;
        $display("FAIL rand_latency it%0d rpc%0d: got %0d, required %0d",
                 it, 1 << k, r.edges, nblk * blk_edges(k) + r.stalls);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      start_s[k] = 1'b0; use_mid_s[k] = 1'b0; mid_s[k] = '0;
      nblk_s[k] = '0; w_valid_s[k] = 1'b0; w_data_s[k] = '0;
    end
    test_reset();
    test_abc();
    test_two_block();
    test_midstate_chain();
    test_backpressure();
    test_zero_blocks();
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
